// File: rtl/spi_master_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | spi_master_pkg : shared widths and FSM encodings for the SPI master  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package spi_master_pkg;
  localparam int c_SPI_DATA_W     = 8;
  localparam int c_SPI_MIN_CLK_DIV = 3;
  localparam int c_BIT_CNT_W      = $clog2(c_SPI_DATA_W);

  localparam int c_STATE_W = 3;
  localparam logic [c_STATE_W-1:0] c_ST_IDLE  = 3'd0;
  localparam logic [c_STATE_W-1:0] c_ST_SETUP = 3'd1;
  localparam logic [c_STATE_W-1:0] c_ST_HIGH  = 3'd2;
  localparam logic [c_STATE_W-1:0] c_ST_LOW   = 3'd3;
  localparam logic [c_STATE_W-1:0] c_ST_DONE  = 3'd4;
endpackage
`default_nettype wire

// File: rtl/spi_master_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | spi_master_if : request/response bus between control logic and SPI   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface spi_master_if;
  import spi_master_pkg::*;

  logic                    start;
  logic [c_SPI_DATA_W-1:0] tx_data;
  logic                    busy;
  logic                    done;
  logic [c_SPI_DATA_W-1:0] rx_data;

  modport master (output start, tx_data, input busy, done, rx_data);
  modport slave  (input start, tx_data, output busy, done, rx_data);
endinterface
`default_nettype wire

// File: rtl/spi_master_clk_gen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | spi_master_clk_gen : half-period tick generator for sclk phases      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module spi_master_clk_gen #(
  parameter int CLK_DIV = 4
) (
  input  wire logic clk,
  input  wire logic rst_n,
  input  wire logic enable,
  output logic      tick
);
  localparam int                 c_CNT_W = $clog2(CLK_DIV);
  localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(CLK_DIV - 1);

  logic [c_CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (!enable || (r_cnt == c_LAST)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign tick = enable && (r_cnt == c_LAST);
endmodule
`default_nettype wire

// File: rtl/spi_master.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | spi_master : SPI mode-0 initiator, single 8-bit full-duplex transfer |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module spi_master
  import spi_master_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  wire logic   clk,
  input  wire logic   rst_n,
  spi_master_if.slave bus,
  input  wire logic   miso,
  output logic        sclk,
  output logic        mosi,
  output logic        cs_n
);
  // Dividers below the slave's settling limit are clamped rather than trusted.
  localparam int c_DIV = (CLK_DIV < c_SPI_MIN_CLK_DIV) ? c_SPI_MIN_CLK_DIV : CLK_DIV;

  logic [c_STATE_W-1:0]    r_state;
  logic [c_SPI_DATA_W-2:0] r_tx_sh;
  logic [c_SPI_DATA_W-1:0] r_rx_sh;
  logic [c_BIT_CNT_W-1:0]  r_bit_cnt;
  logic                    r_start_q;
  logic                    w_enable;
  logic                    w_tick;
  logic                    w_accept;
  logic                    w_last_low;

  assign w_enable   = (r_state == c_ST_SETUP) || (r_state == c_ST_HIGH) || (r_state == c_ST_LOW);
  // A start held across DONE chains straight into SETUP; a fresh pulse in DONE is ignored.
  assign w_accept   = bus.start && ((r_state == c_ST_IDLE) || ((r_state == c_ST_DONE) && r_start_q));
  assign w_last_low = (r_state == c_ST_LOW) && (r_bit_cnt == '0);

  spi_master_clk_gen #(
    .CLK_DIV (c_DIV)
  ) u_clk_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (w_enable),
    .tick   (w_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= c_ST_IDLE;
      r_tx_sh     <= '0;
      r_rx_sh     <= '0;
      r_bit_cnt   <= '0;
      r_start_q   <= 1'b0;
      sclk        <= 1'b0;
      mosi        <= 1'b0;
      cs_n        <= 1'b1;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.rx_data <= '0;
    end else begin
      r_start_q <= bus.start;
      bus.done  <= 1'b0;
      case (r_state)
        c_ST_IDLE, c_ST_DONE: begin
          if (w_accept) begin
            r_state   <= c_ST_SETUP;
            cs_n      <= 1'b0;
            bus.busy  <= 1'b1;
            mosi      <= bus.tx_data[c_SPI_DATA_W-1];
            r_tx_sh   <= bus.tx_data[c_SPI_DATA_W-2:0];
            r_rx_sh   <= '0;
            r_bit_cnt <= '0;
          end else begin
            r_state <= c_ST_IDLE;
          end
        end
        c_ST_SETUP, c_ST_LOW: begin
          if (w_tick) begin
            if (w_last_low) begin
              r_state     <= c_ST_DONE;
              cs_n        <= 1'b1;
              bus.busy    <= 1'b0;
              bus.done    <= 1'b1;
              bus.rx_data <= r_rx_sh;
              mosi        <= 1'b0;
            end else begin
              r_state   <= c_ST_HIGH;
              sclk      <= 1'b1;
              r_rx_sh   <= {r_rx_sh[c_SPI_DATA_W-2:0], miso};
              r_bit_cnt <= r_bit_cnt + 1'b1;
            end
          end
        end
        c_ST_HIGH: begin
          if (w_tick) begin
            r_state <= c_ST_LOW;
            sclk    <= 1'b0;
            // The bit counter has wrapped to zero after the eighth rising edge.
            if (r_bit_cnt != '0) begin
              mosi    <= r_tx_sh[c_SPI_DATA_W-2];
              r_tx_sh <= {r_tx_sh[c_SPI_DATA_W-3:0], 1'b0};
            end
          end
        end
        default: r_state <= c_ST_IDLE;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_spi_master.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_spi_master : SPI master against a behavioural mode-0 slave        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_spi_master;
  typedef struct {
    logic [7:0] tx;
    logic [7:0] sd;
    logic [7:0] exp_rx;
    logic [7:0] exp_srx;
    int         exp_lat;
    int         exp_mosi_hi;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  logic [2:0]      start_v = '0;
  logic [2:0][7:0] tx_v = '0;
  logic [2:0][7:0] sdin_v = '0;
  logic [2:0]      busy_v, done_v, sclk_v, mosi_v, cs_v;
  logic [2:0][7:0] rx_v, srx_v;

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int h_of(input int k);
    return (k == 0) ? 4 : (k == 1) ? 3 : 7;
  endfunction

  // One SETUP phase plus eight high/low pairs, then DONE follows one edge later.
  function automatic int model_lat(input int h);
    return 1 + (1 + 2 * 8) * h;
  endfunction

  generate
    for (genvar i = 0; i < 3; i++) begin : g_dut
      localparam int c_H = (i == 0) ? 4 : (i == 1) ? 3 : 7;
      spi_master_if bus ();
      logic       miso = 1'b0;
      logic       p_sclk = 1'b0;
      logic       p_cs = 1'b1;
      logic [7:0] s_sh = '0;
      logic [7:0] s_rx = '0;

      assign bus.start   = start_v[i];
      assign bus.tx_data = tx_v[i];
      assign busy_v[i]   = bus.busy;
      assign done_v[i]   = bus.done;
      assign rx_v[i]     = bus.rx_data;
      assign srx_v[i]    = s_rx;

      spi_master #(.CLK_DIV(c_H)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .miso  (miso),
        .sclk  (sclk_v[i]),
        .mosi  (mosi_v[i]),
        .cs_n  (cs_v[i])
      );

      // Slave with a sampled edge detect on sclk/cs_n, like a real spi_slave.
      always @(posedge clk) begin
        p_sclk <= sclk_v[i];
        p_cs   <= cs_v[i];
        if (p_cs && !cs_v[i]) begin
          s_sh <= sdin_v[i];
          miso <= sdin_v[i][7];
        end else if (!cs_v[i] && !p_sclk && sclk_v[i]) begin
          s_rx <= {s_rx[6:0], mosi_v[i]};
        end else if (!cs_v[i] && p_sclk && !sclk_v[i]) begin
          miso <= s_sh[6];
          s_sh <= {s_sh[6:0], 1'b0};
        end
      end
    end
  endgenerate

  int   rise_cnt = 0, done_cnt = 0, busy_fall = 0, mosi_hi = 0, cs_run = 0, cs_last_run = 0;
  logic m_sclk = 1'b0, m_busy = 1'b0, m_cs = 1'b1;

  always @(negedge clk) begin
    m_sclk <= sclk_v[0];
    m_busy <= busy_v[0];
    m_cs   <= cs_v[0];
    if (sclk_v[0] && !m_sclk && !cs_v[0]) rise_cnt <= rise_cnt + 1;
    if (done_v[0]) done_cnt <= done_cnt + 1;
    if (m_busy && !busy_v[0]) busy_fall <= busy_fall + 1;
    if (!cs_v[0] && mosi_v[0]) mosi_hi <= mosi_hi + 1;
    if (cs_v[0]) cs_run <= cs_run + 1;
    else if (m_cs) begin
      cs_last_run <= cs_run;
      cs_run      <= 0;
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic wait_idle(input int k);
    bit ok = 0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (!busy_v[k] && !done_v[k]) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("idle_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic start_xfer(input int k, input logic [7:0] tx, input logic [7:0] sd, output int t0);
    sdin_v[k]  = sd;
    tx_v[k]    = tx;
    start_v[k] = 1'b1;
    t0         = cyc;
    @(posedge clk);
    #1;
    start_v[k] = 1'b0;
    tx_v[k]    = 8'($urandom);
  endtask

  task automatic wait_done(input int k, input int t0, output int lat);
    lat = -1;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (done_v[k]) begin
        lat = cyc - t0;
        break;
      end
    end
  endtask

  task automatic run_xfer(input int k, input logic [7:0] tx, input logic [7:0] sd,
                          output logic [7:0] rx, output logic [7:0] srx, output int lat);
    int t0;
    wait_idle(k);
    start_xfer(k, tx, sd, t0);
    wait_done(k, t0, lat);
    rx  = rx_v[k];
    srx = srx_v[k];
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, want test end");
    $fatal(1);
  end

  initial begin
    vec_t       tbl [4];
    logic [7:0] rx, srx, rx1, srx1;
    logic [7:0] tx, sd;
    int         lat, lat1, t0, t1, br, bm, bd, bb;

    tbl[0] = '{8'hA5, 8'h3C, 8'h3C, 8'hA5, 69, 36};
    tbl[1] = '{8'h00, 8'hFF, 8'hFF, 8'h00, 69, 0};
    tbl[2] = '{8'hFF, 8'h00, 8'h00, 8'hFF, 69, 68};
    tbl[3] = '{8'h81, 8'h7E, 8'h7E, 8'h81, 69, 20};

    repeat (3) @(negedge clk);
    chk("rst_sclk", sclk_v[0], 0);
    chk("rst_cs_n", cs_v, 3'b111);
    chk("rst_mosi", mosi_v[0], 0);
    chk("rst_busy", busy_v, 0);
    chk("rst_done", done_v, 0);
    chk("rst_rx", rx_v[0], 0);
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      br = rise_cnt;
      bm = mosi_hi;
      run_xfer(0, tbl[i].tx, tbl[i].sd, rx, srx, lat);
      repeat (2) @(negedge clk);
      #1;
      chk($sformatf("vec%0d_rx", i), rx, tbl[i].exp_rx);
      chk($sformatf("vec%0d_slave_rx", i), srx, tbl[i].exp_srx);
      chk($sformatf("vec%0d_latency", i), lat, tbl[i].exp_lat);
      chk($sformatf("vec%0d_rises", i), rise_cnt - br, 8);
      chk($sformatf("vec%0d_mosi_hi", i), mosi_hi - bm, tbl[i].exp_mosi_hi);
    end

    // Start pulses mid-transfer must not queue a second transfer.
    wait_idle(0);
    bd = done_cnt;
    bb = busy_fall;
    start_xfer(0, 8'h5A, 8'hC3, t0);
    repeat (9) begin @(posedge clk); #1; end
    start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    repeat (29) begin @(posedge clk); #1; end
    start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    wait_done(0, t0, lat);
    chk("busy_rej_latency", lat, model_lat(4));
    chk("busy_rej_rx", rx_v[0], 8'hC3);
    chk("busy_rej_slave_rx", srx_v[0], 8'h5A);
    repeat (100) @(negedge clk);
    #1;
    chk("busy_rej_done_count", done_cnt - bd, 1);
    chk("busy_rej_busy_falls", busy_fall - bb, 1);
    chk("busy_rej_idle", busy_v[0], 0);

    // Back-to-back with start held high.
    wait_idle(0);
    sdin_v[0]  = 8'h7E;
    tx_v[0]    = 8'h81;
    start_v[0] = 1'b1;
    t0         = cyc;
    repeat (10) begin @(posedge clk); #1; end
    tx_v[0]   = 8'h7E;
    sdin_v[0] = 8'h81;
    wait_done(0, t0, lat1);
    rx1  = rx_v[0];
    srx1 = srx_v[0];
    t1   = cyc;
    chk("b2b_done_cs_high", cs_v[0], 1);
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    wait_done(0, t1, lat);
    chk("b2b_lat1", lat1, model_lat(4));
    chk("b2b_rx1", rx1, 8'h7E);
    chk("b2b_slave_rx1", srx1, 8'h81);
    chk("b2b_lat2", lat, model_lat(4));
    chk("b2b_rx2", rx_v[0], 8'h81);
    chk("b2b_slave_rx2", srx_v[0], 8'h7E);
    chk("b2b_cs_high_cycles", cs_last_run, 1);

    // Reset asserted during the third sclk high phase.
    wait_idle(0);
    bd = done_cnt;
    br = rise_cnt;
    start_xfer(0, 8'h96, 8'h69, t0);
    for (int n = 0; n < 500; n++) begin
      @(negedge clk); #1;
      if (rise_cnt - br >= 3) break;
    end
    chk("mid_rst_rises_seen", rise_cnt - br, 3);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_sclk", sclk_v[0], 0);
    chk("mid_rst_cs_n", cs_v[0], 1);
    chk("mid_rst_busy", busy_v[0], 0);
    chk("mid_rst_rx", rx_v[0], 0);
    chk("mid_rst_mosi", mosi_v[0], 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    chk("mid_rst_no_done", done_cnt - bd, 0);
    run_xfer(0, 8'hC3, 8'h5A, rx, srx, lat);
    chk("post_rst_rx", rx, 8'h5A);
    chk("post_rst_slave_rx", srx, 8'hC3);
    chk("post_rst_latency", lat, model_lat(4));

    // Random bytes across all three dividers.
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < 6; j++) begin
        tx = 8'($urandom);
        sd = 8'($urandom);
        run_xfer(k, tx, sd, rx, srx, lat);
        chk($sformatf("rand_h%0d_rx", h_of(k)), rx, sd);
        chk($sformatf("rand_h%0d_slave_rx", h_of(k)), srx, tx);
        chk($sformatf("rand_h%0d_latency", h_of(k)), lat, model_lat(h_of(k)));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
